// File: rtl/plc_arb_pkg.sv
// Shared types and constants for the PLC AXI4-Lite arbiter.
package plc_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR,
      WR_RESP,
      RD_ADDR,
      RD_DATA,
      DONE
   } arb_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [3:0] REG0 = 4'h0;
   localparam logic [3:0] REG1 = 4'h4;
   localparam logic [3:0] REG2 = 4'h8;
   localparam logic [3:0] REG3 = 4'hC;

endpackage

// File: rtl/plc_rr_pick.sv
// Combinational round-robin selector: first request at or after rr_ptr.
module plc_rr_pick
   import plc_arb_pkg::*;
#(
   parameter int N_REQ = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] gnt_oh,
   output logic [PTR_W-1:0] gnt_idx,
   output logic             hit
);

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      hit     = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!hit && req[(int'(rr_ptr) + k) % N_REQ]) begin
            hit     = 1'b1;
            gnt_idx = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            gnt_oh  = N_REQ'(1) << ((int'(rr_ptr) + k) % N_REQ);
         end
      end
   end

endmodule

// File: rtl/plc_axil_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among N_REQ requesters.
module plc_axil_arbiter
   import plc_arb_pkg::*;
#(
   parameter int N_REQ  = 2,
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_we,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    busy,
   output logic [ADDR_W-1:0]       m_axi_awaddr,
   output logic [2:0]              m_axi_awprot,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_W-1:0]       m_axi_wdata,
   output logic [DATA_W/8-1:0]     m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_W-1:0]       m_axi_araddr,
   output logic [2:0]              m_axi_arprot,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_W-1:0]       m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

   arb_state_t        state_q, state_d;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]  gnt_q, gnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;
   logic              awvalid_q, awvalid_d;
   logic              wvalid_q, wvalid_d;
   logic              bready_q, bready_d;
   logic              arvalid_q, arvalid_d;
   logic              rready_q, rready_d;

   logic [N_REQ-1:0]  pick_oh;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_hit;
   logic              grant;
   logic              aw_done;
   logic              w_done;
   logic [ADDR_W-1:0] sel_addr;

   plc_rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req     (req_valid),
      .rr_ptr  (rr_ptr_q),
      .gnt_oh  (pick_oh),
      .gnt_idx (pick_idx),
      .hit     (pick_hit)
   );

   // No accept pulse while reset is held, so outputs stay quiet.
   assign grant   = pick_hit && !ARESET && (state_q == IDLE);
   assign aw_done = !awvalid_q || m_axi_awready;
   assign w_done  = !wvalid_q || m_axi_wready;

   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      sel_addr  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
      sel_addr[1:0] = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (grant) begin
               gnt_d    = pick_idx;
               rr_ptr_d = PTR_W'((int'(pick_idx) + 1) % N_REQ);
               addr_d   = sel_addr;
               wdata_d  = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
               if (req_we[pick_idx]) begin
                  state_d   = WR;
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
               end else begin
                  state_d   = RD_ADDR;
                  arvalid_d = 1'b1;
               end
            end
         end
         WR: begin
            if (m_axi_awready) awvalid_d = 1'b0;
            if (m_axi_wready) wvalid_d = 1'b0;
            if (aw_done && w_done) begin
               state_d  = WR_RESP;
               bready_d = 1'b1;
            end
         end
         WR_RESP: begin
            if (m_axi_bvalid) begin
               resp_d   = m_axi_bresp;
               rdata_d  = '0;
               bready_d = 1'b0;
               state_d  = DONE;
            end
         end
         RD_ADDR: begin
            if (m_axi_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axi_rvalid) begin
               resp_d   = m_axi_rresp;
               rdata_d  = m_axi_rdata;
               rready_d = 1'b0;
               state_d  = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_ptr_q  <= rr_ptr_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
      end
   end

   assign req_ready = grant ? pick_oh : '0;
   assign rsp_valid = (state_q == DONE) ? (N_REQ'(1) << gnt_q) : '0;
   assign rsp_rdata = rdata_q;
   assign rsp_resp  = resp_q;
   assign busy      = (state_q != IDLE) || grant;

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awprot  = 3'b000;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = '1;
   assign m_axi_wvalid  = wvalid_q;
   assign m_axi_bready  = bready_q;
   assign m_axi_araddr  = addr_q;
   assign m_axi_arprot  = 3'b000;
   assign m_axi_arvalid = arvalid_q;
   assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_plc_axil_arbiter.sv
// Randomised bench for plc_axil_arbiter against a register-file/round-robin model.
module tb_plc_axil_arbiter;
   import plc_arb_pkg::*;

   localparam int N  = 2;
   localparam int AW = 4;
   localparam int DW = 32;

   logic            ACLK = 1'b0;
   logic            ARESET;
   logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;
   logic            busy;
   logic [AW-1:0]   m_axi_awaddr, m_axi_araddr;
   logic [2:0]      m_axi_awprot, m_axi_arprot;
   logic            m_axi_awvalid, m_axi_awready;
   logic [DW-1:0]   m_axi_wdata, m_axi_rdata;
   logic [DW/8-1:0] m_axi_wstrb;
   logic            m_axi_wvalid, m_axi_wready;
   logic [1:0]      m_axi_bresp, m_axi_rresp;
   logic            m_axi_bvalid, m_axi_bready;
   logic            m_axi_arvalid, m_axi_arready;
   logic            m_axi_rvalid, m_axi_rready;

   always #5 ACLK = ~ACLK;

   plc_axil_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
      .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   // Slave: 4-word register file with tunable ready delays.
   int         aw_wait = 0, w_wait = 0, ar_wait = 0;
   logic [1:0] err_resp = 2'b00;
   bit         hold_r = 0;
   int         aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
   logic [DW-1:0] smem [4] = '{default: '0};
   logic          got_aw = 0, got_w = 0;
   logic [AW-1:0] s_awaddr = '0, wa;
   logic [DW-1:0] s_wdata = '0, wd;

   assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
   assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_wait);
   assign m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_wait);
   assign wa = (m_axi_awvalid && m_axi_awready) ? m_axi_awaddr : s_awaddr;
   assign wd = (m_axi_wvalid && m_axi_wready) ? m_axi_wdata : s_wdata;

   always @(posedge ACLK) begin
      if (ARESET) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         got_aw <= 0; got_w <= 0;
         m_axi_bvalid <= 0; m_axi_rvalid <= 0;
         m_axi_bresp <= 0; m_axi_rresp <= 0; m_axi_rdata <= 0;
      end else begin
         aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
         ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
         if (m_axi_awvalid && m_axi_awready) begin
            got_aw <= 1; s_awaddr <= m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            got_w <= 1; s_wdata <= m_axi_wdata;
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 0;
         if ((got_aw || (m_axi_awvalid && m_axi_awready)) &&
             (got_w || (m_axi_wvalid && m_axi_wready))) begin
            smem[wa[3:2]] <= wd;
            m_axi_bvalid <= 1; m_axi_bresp <= err_resp;
            got_aw <= 0; got_w <= 0;
         end
         if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 0;
         if (m_axi_arvalid && m_axi_arready && !hold_r) begin
            m_axi_rvalid <= 1;
            m_axi_rdata  <= smem[m_axi_araddr[3:2]];
            m_axi_rresp  <= err_resp;
         end
      end
   end

   // Channel monitor
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, awv_cyc = 0, wv_cyc = 0;
   logic [AW-1:0] last_awaddr = '0, last_araddr = '0;
   logic [DW-1:0] last_wdata = '0;
   logic [3:0]    last_wstrb = '0;
   logic [2:0]    prot_or = '0;

   always @(posedge ACLK) begin
      if (!ARESET) begin
         prot_or = prot_or | m_axi_awprot | m_axi_arprot;
         if (m_axi_awvalid) awv_cyc++;
         if (m_axi_wvalid) wv_cyc++;
         if (m_axi_awvalid && m_axi_awready) begin
            n_aw++; last_awaddr = m_axi_awaddr;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            n_w++; last_wdata = m_axi_wdata; last_wstrb = m_axi_wstrb;
         end
         if (m_axi_bvalid && m_axi_bready) n_b++;
         if (m_axi_arvalid && m_axi_arready) begin
            n_ar++; last_araddr = m_axi_araddr;
         end
      end
   end

   int checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: register file contents and round-robin pointer.
   logic [DW-1:0] mmem [4] = '{default: '0};
   int            mptr = 0;

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   function automatic int model_pick(input logic [N-1:0] p, input int ptr);
      for (int k = 0; k < N; k++)
         if (p[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic run_batch(input logic [N-1:0] mask,
                            input logic [N-1:0] we,
                            input logic [N*AW-1:0] addr,
                            input logic [N*DW-1:0] wdata,
                            input bit exact);
      logic [N-1:0]  pend;
      bit            outst, owe;
      int            owner, gcyc, g, cyc;
      int            aw0, w0, b0, ar0;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd, erd;
      logic [1:0]    ers;
      pend = mask; outst = 0; owe = 0; owner = 0; gcyc = 0; cyc = 0;
      aw0 = 0; w0 = 0; b0 = 0; ar0 = 0; ea = '0; ewd = '0; erd = '0; ers = '0;
      while ((pend != 0 || outst) && cyc < 300) begin
         req_valid = pend; req_we = we; req_addr = addr; req_wdata = wdata;
         #1;
         g = outst ? -1 : model_pick(pend, mptr);
         chk("req_ready", req_ready, (g >= 0) ? oh(g) : '0);
         chk("busy", busy, outst || (g >= 0));
         if (outst) begin
            if (exact)
               chk("rsp_latency", rsp_valid, (cyc == gcyc + 3) ? oh(owner) : '0);
            else if (rsp_valid != 0)
               chk("rsp_owner", rsp_valid, oh(owner));
            if (rsp_valid != 0) begin
               chk("rsp_rdata", rsp_rdata, erd);
               chk("rsp_resp", rsp_resp, ers);
               chk("prot", prot_or, 0);
               if (owe) begin
                  chk("aw_count", n_aw - aw0, 1);
                  chk("w_count", n_w - w0, 1);
                  chk("b_count", n_b - b0, 1);
                  chk("ar_none", n_ar - ar0, 0);
                  chk("awaddr", last_awaddr, ea);
                  chk("wdata", last_wdata, ewd);
                  chk("wstrb", last_wstrb, 4'hF);
               end else begin
                  chk("ar_count", n_ar - ar0, 1);
                  chk("aw_none", n_aw - aw0, 0);
                  chk("araddr", last_araddr, ea);
               end
               outst = 0;
            end
         end else begin
            chk("rsp_idle", rsp_valid, '0);
         end
         if (g >= 0) begin
            outst = 1; owner = g; gcyc = cyc; pend[g] = 1'b0;
            mptr = (g + 1) % N;
            owe = we[g];
            ea = addr[g*AW +: AW] & 4'hC;
            ewd = wdata[g*DW +: DW];
            ers = err_resp;
            aw0 = n_aw; w0 = n_w; b0 = n_b; ar0 = n_ar;
            if (owe) begin
               mmem[ea[3:2]] = ewd;
               erd = '0;
            end else begin
               erd = mmem[ea[3:2]];
            end
         end
         @(posedge ACLK); #1;
         cyc++;
      end
      chk("batch_done", (pend != 0) || outst, 0);
      req_valid = '0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int awv0, wv0;
      logic [N-1:0] m, w;
      logic [N*AW-1:0] a;
      logic [N*DW-1:0] d;
      ARESET = 1; req_valid = '1; req_we = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge ACLK);
      #1;
      chk("rst_req_ready", req_ready, '0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_rdata", rsp_rdata, '0);
      chk("rst_resp", rsp_resp, '0);
      chk("rst_axi_valids",
          {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
      chk("rst_prot", {m_axi_awprot, m_axi_arprot}, 0);
      req_valid = '0;
      ARESET = 0;
      @(posedge ACLK); #1;

      // single write then readback
      run_batch(2'b01, 2'b01, {4'h0, REG1}, {32'h0, 32'hCAFEBABE}, 1);
      run_batch(2'b01, 2'b00, {4'h0, REG1}, '0, 1);
      chk("readback_lit", rsp_rdata, 32'hCAFEBABE);

      // skewed write channels
      aw_wait = 3;
      awv0 = awv_cyc; wv0 = wv_cyc;
      run_batch(2'b01, 2'b01, {4'h0, REG2}, {32'h0, 32'h55AA1234}, 0);
      chk("skew_awvalid_cycles", awv_cyc - awv0, 4);
      chk("skew_wvalid_cycles", wv_cyc - wv0, 1);
      aw_wait = 0;

      // error passthrough
      err_resp = RESP_SLVERR;
      run_batch(2'b10, 2'b10, {REG3, 4'h0}, {32'h12345678, 32'h0}, 1);
      chk("slverr_lit", rsp_resp, RESP_SLVERR);
      run_batch(2'b10, 2'b00, {REG3, 4'h0}, '0, 1);
      err_resp = RESP_OKAY;

      // reset while waiting in RD_DATA
      hold_r = 1;
      req_valid = 2'b01; req_we = 2'b00; req_addr = {4'h0, 4'h6};
      #1;
      chk("rst_txn_grant", req_ready, oh(model_pick(2'b01, mptr)));
      @(posedge ACLK); #1;
      req_valid = '0;
      @(posedge ACLK); #1;
      chk("rst_txn_rready", m_axi_rready, 1);
      chk("rst_txn_busy", busy, 1);
      ARESET = 1;
      @(posedge ACLK); #1;
      ARESET = 0;
      #1;
      chk("midrst_outputs", {req_ready, rsp_valid, busy, rsp_resp}, 0);
      chk("midrst_rdata", rsp_rdata, '0);
      chk("midrst_axi",
          {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
      repeat (4) begin
         @(posedge ACLK); #1;
         chk("midrst_no_rsp", {rsp_valid, busy}, 0);
      end
      hold_r = 0;
      mptr = 0;

      // contention after reset, twice
      run_batch(2'b11, 2'b00, {REG1, REG2}, '0, 1);
      run_batch(2'b11, 2'b11, {REG0, REG3}, {32'hA5A5_0001, 32'h5A5A_0002}, 1);

      // fill and verify
      for (int k = 0; k < 4; k++) begin
         m = oh(k % 2);
         a = {N{4'(k * 4)}};
         d = {N{32'(k + 1)}};
         run_batch(m, m, a, d, 1);
      end
      for (int k = 0; k < 4; k++) begin
         m = oh(k % 2);
         a = {N{4'(k * 4)}};
         run_batch(m, 2'b00, a, '0, 1);
         chk("fill_readback", rsp_rdata, 32'(k + 1));
      end

      // randomised traffic
      for (int t = 0; t < 200; t++) begin
         m = N'($urandom_range(1, (1 << N) - 1));
         w = N'($urandom);
         a = (N*AW)'($urandom);
         d = {$urandom, $urandom};
         aw_wait = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
         w_wait  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
         ar_wait = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0;
         err_resp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
         run_batch(m, w, a, d, (aw_wait == 0) && (w_wait == 0) && (ar_wait == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
